// File: rtl/counter_pkg.sv
// Shared definitions for the modulo/preset counter.
//   - Mode encodings driven on the counter's mode port.
//   - One-shot sequencer state encodings.
//   - default_limit(): reset value of the limit register (0 selects all-ones).
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic [63:0] default_limit(input int bits, input int maxvalue);
        if (maxvalue != 0) begin
            return 64'(maxvalue);
        end
        return (64'd1 << bits) - 64'd1;
    endfunction

endpackage

// File: rtl/counter_oneshot_fsm.sv
// One-shot sequencer for counter_modulo_preset.
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   clr_i       synchronous clear, forces IDLE
//   oneshot_i   one-shot mode selected; when low the FSM is held in IDLE
//   start_i     qualified start (already masked by higher-priority actions)
//   boundary_i  qualified boundary event while running
//   busy_o      registered, high while in RUN
//   done_o      registered, one-cycle pulse in DONE
//   run_o       state is RUN (datapath count enable in one-shot mode)
//   idle_o      state is IDLE (datapath may accept a start)
module counter_oneshot_fsm
    import counter_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic oneshot_i,
    input  logic start_i,
    input  logic boundary_i,
    output logic busy_o,
    output logic done_o,
    output logic run_o,
    output logic idle_o
);

    state_e state_q;
    logic   busy_q;
    logic   done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (clr_i || !oneshot_i) begin
            // Aborting a run never produces a done pulse.
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                    done_q <= 1'b0;
                end
                ST_RUN: begin
                    if (boundary_i) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign run_o  = (state_q == ST_RUN);
    assign idle_o = (state_q == ST_IDLE);

endmodule

// File: rtl/counter_modulo_preset.sv
// Up/down counter with preset load, runtime-programmable modulo limit and
// wrap / saturate / one-shot modes.
// Ports:
//   c       clock, rising edge
//   clr_n   asynchronous active-low reset
//   clr     synchronous clear (limit kept)
//   en      count enable
//   dir     0 = up, 1 = down
//   ld/in   synchronous preset load, clamped to the limit
//   max_ld/max_in  load a new limit; out is clamped down to it
//   mode    00 wrap, 01 saturate, 10 one-shot, 11 behaves as wrap
//   start   one-shot start request
//   out     registered count
//   ovf     registered boundary-event pulse
//   tc      combinational terminal count for the current dir
//   busy    one-shot run in progress
//   done    one-cycle one-shot completion pulse
module counter_modulo_preset
    import counter_pkg::*;
#(
    parameter int BITS     = 8,
    parameter int MAXVALUE = 0
) (
    input  logic            c,
    input  logic            clr_n,
    input  logic            clr,
    input  logic            en,
    input  logic            dir,
    input  logic            ld,
    input  logic [BITS-1:0] in,
    input  logic            max_ld,
    input  logic [BITS-1:0] max_in,
    input  logic [1:0]      mode,
    input  logic            start,
    output logic [BITS-1:0] out,
    output logic            ovf,
    output logic            tc,
    output logic            busy,
    output logic            done
);

    localparam logic [BITS-1:0] LIMIT_RST = BITS'(default_limit(BITS, MAXVALUE));

    logic [BITS-1:0] out_q, out_d;
    logic [BITS-1:0] limit_q, limit_d;
    logic            ovf_q, ovf_d;

    logic oneshot;
    logic saturating;
    logic clamp;
    logic start_go;
    logic count_ok;
    logic boundary;
    logic fsm_run;
    logic fsm_idle;

    always_comb begin
        oneshot    = (mode == MODE_ONESHOT);
        // One-shot runs saturate at the boundary; reserved mode behaves as wrap.
        saturating = (mode == MODE_SAT) || oneshot;

        limit_d = limit_q;
        if (!clr && max_ld) begin
            limit_d = max_in;
        end

        tc = dir ? (out_q == '0) : (out_q == limit_q);

        clamp    = max_ld && (out_q > max_in);
        start_go = oneshot && fsm_idle && start && !clr && !ld && !clamp;
        count_ok = !clr && !ld && !clamp && !start_go && en && (!oneshot || fsm_run);
        boundary = count_ok && tc;

        out_d = out_q;
        ovf_d = 1'b0;
        if (clr) begin
            out_d = '0;
        end else if (ld) begin
            out_d = in;
        end else if (clamp) begin
            out_d = max_in;
        end else if (start_go) begin
            out_d = dir ? limit_d : '0;
        end else if (count_ok) begin
            if (tc) begin
                ovf_d = 1'b1;
                if (!saturating) begin
                    out_d = dir ? limit_q : '0;
                end
            end else if (dir) begin
                out_d = out_q - BITS'(1);
            end else begin
                out_d = out_q + BITS'(1);
            end
        end

        // The count never exceeds the limit that takes effect on this edge:
        // this bounds preset loads and a limit lowered while counting.
        if (out_d > limit_d) begin
            out_d = limit_d;
        end
    end

    always_ff @(posedge c or negedge clr_n) begin
        if (!clr_n) begin
            out_q   <= '0;
            limit_q <= LIMIT_RST;
            ovf_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            limit_q <= limit_d;
            ovf_q   <= ovf_d;
        end
    end

    counter_oneshot_fsm u_fsm (
        .clk_i      (c),
        .rst_ni     (clr_n),
        .clr_i      (clr),
        .oneshot_i  (oneshot),
        .start_i    (start_go),
        .boundary_i (boundary),
        .busy_o     (busy),
        .done_o     (done),
        .run_o      (fsm_run),
        .idle_o     (fsm_idle)
    );

    assign out = out_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_counter_modulo_preset.sv
// Scoreboard bench for counter_modulo_preset (BITS=3, MAXVALUE=0).
// The driver applies one stimulus set per cycle, pushes the outputs expected
// to be visible during that cycle, then advances the reference model across
// the coming clock edge. A monitor pops and compares on every falling edge.
module tb_counter_modulo_preset;

    localparam int BITS = 3;
    localparam int P_IDLE = 0, P_RUN = 1, P_DONE = 2;

    logic            c = 1'b0;
    logic            clr_n = 1'b0;
    logic            clr = 1'b0, en = 1'b0, dir = 1'b0, ld = 1'b0;
    logic [BITS-1:0] in = '0, max_in = '0;
    logic            max_ld = 1'b0, start = 1'b0;
    logic [1:0]      mode = 2'b00;
    logic [BITS-1:0] out;
    logic            ovf, tc, busy, done;

    counter_modulo_preset #(.BITS(BITS), .MAXVALUE(0)) dut (
        .c(c), .clr_n(clr_n), .clr(clr), .en(en), .dir(dir), .ld(ld), .in(in),
        .max_ld(max_ld), .max_in(max_in), .mode(mode), .start(start),
        .out(out), .ovf(ovf), .tc(tc), .busy(busy), .done(done)
    );

    always #5 c = ~c;

    typedef struct {
        int e_out;
        bit e_ovf;
        bit e_tc;
        bit e_busy;
        bit e_done;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Stimulus for the next cycle.
    bit d_rstn = 0, d_clr = 0, d_en = 0, d_dir = 0, d_ld = 0, d_mld = 0, d_start = 0;
    int d_in = 0, d_min = 0, d_mode = 0;

    // Reference model: count value, limit, one-shot phase, last ovf.
    int m_out = 0, m_lim = 7, m_ph = P_IDLE;
    bit m_ovf = 0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        m_out = 0; m_lim = (1 << BITS) - 1; m_ph = P_IDLE; m_ovf = 0;
    endtask

    task automatic model_edge();
        bit os, at_edge;
        int new_lim, nph;
        if (!d_rstn) begin
            model_reset();
            return;
        end
        m_ovf = 0;
        if (d_clr) begin
            m_out = 0;
            m_ph  = P_IDLE;
            return;
        end
        os      = (d_mode == 2);
        new_lim = d_mld ? d_min : m_lim;
        nph     = (!os || m_ph == P_DONE) ? P_IDLE : m_ph;
        if (d_ld) begin
            m_out = imin(d_in, new_lim);
        end else if (d_mld && m_out > d_min) begin
            m_out = d_min;
        end else if (os && m_ph == P_IDLE && d_start) begin
            m_out = d_dir ? new_lim : 0;
            nph   = P_RUN;
        end else if (d_en && (!os || m_ph == P_RUN)) begin
            at_edge = d_dir ? (m_out == 0) : (m_out == m_lim);
            m_ovf   = at_edge;
            if (os || d_mode == 1) begin
                m_out = d_dir ? imax(m_out - 1, 0) : imin(m_out + 1, m_lim);
                if (os && at_edge) nph = P_DONE;
            end else begin
                m_out = d_dir ? (m_out + m_lim) % (m_lim + 1) : (m_out + 1) % (m_lim + 1);
            end
            m_out = imin(m_out, new_lim);
        end
        m_lim = new_lim;
        m_ph  = nph;
    endtask

    // One cycle: drive inputs away from the edge, record what this cycle
    // must show, then step the model through the coming rising edge.
    task automatic tick();
        exp_t e;
        @(posedge c);
        #2;
        clr_n = d_rstn; clr = d_clr; en = d_en; dir = d_dir; ld = d_ld;
        in = BITS'(d_in); max_ld = d_mld; max_in = BITS'(d_min);
        mode = 2'(d_mode); start = d_start;
        if (!d_rstn) model_reset();
        e.e_out  = m_out;
        e.e_ovf  = m_ovf;
        e.e_tc   = d_dir ? (m_out == 0) : (m_out == m_lim);
        e.e_busy = (m_ph == P_RUN);
        e.e_done = (m_ph == P_DONE);
        sb.push_back(e);
        model_edge();
    endtask

    task automatic idle_inputs();
        d_clr = 0; d_en = 0; d_ld = 0; d_mld = 0; d_start = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge c) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("out",  32'(out),  32'(e.e_out));
            chk("ovf",  32'(ovf),  32'(e.e_ovf));
            chk("tc",   32'(tc),   32'(e.e_tc));
            chk("busy", 32'(busy), 32'(e.e_busy));
            chk("done", 32'(done), 32'(e.e_done));
        end
    end

    initial begin
        // Reset, then wrap counting through the full range.
        d_rstn = 0;
        repeat (2) tick();
        d_rstn = 1; d_mode = 0; d_dir = 0; d_en = 1;
        repeat (9) tick();

        // Lower the limit while at 7: clamp wins over counting.
        for (int i = 0; i < 8 && m_out != 7; i++) tick();
        d_mld = 1; d_min = 5;
        tick();
        d_mld = 0;
        repeat (7) tick();
        d_ld = 1; d_in = 7;
        tick();
        idle_inputs();
        tick();

        // Saturate down from a preset of 2.
        d_mode = 1; d_ld = 1; d_in = 2; d_dir = 1;
        tick();
        d_ld = 0; d_en = 1;
        repeat (5) tick();

        // One-shot up to limit 4, then restart.
        idle_inputs();
        d_mld = 1; d_min = 4;
        tick();
        d_mld = 0; d_mode = 2; d_dir = 0; d_start = 1;
        tick();
        d_start = 0; d_en = 1;
        repeat (8) tick();
        d_start = 1;
        tick();
        d_start = 0;
        repeat (3) tick();

        // Asynchronous reset in the middle of a run.
        d_rstn = 0;
        repeat (2) tick();
        d_rstn = 1;
        tick();

        // Simultaneous requests.
        d_mode = 2; d_start = 1;
        tick();
        d_start = 0; d_en = 1;
        repeat (2) tick();
        d_clr = 1; d_ld = 1; d_in = 5; d_start = 1;
        tick();
        idle_inputs();
        d_mode = 0; d_ld = 1; d_in = 3; d_en = 1;
        tick();
        d_ld = 0;
        tick();
        d_mld = 1; d_min = 0;
        tick();
        d_mld = 0;
        repeat (4) tick();
        d_dir = 1;
        repeat (2) tick();

        // Randomised traffic.
        idle_inputs();
        for (int i = 0; i < 600; i++) begin
            d_rstn  = ($urandom_range(0, 199) != 0);
            d_clr   = ($urandom_range(0, 39) == 0);
            d_en    = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 7) == 0) d_dir = ~d_dir;
            d_ld    = ($urandom_range(0, 19) == 0);
            d_in    = int'($urandom_range(0, 7));
            d_mld   = ($urandom_range(0, 24) == 0);
            d_min   = int'($urandom_range(0, 7));
            d_start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 29) == 0) d_mode = int'($urandom_range(0, 3));
            tick();
        end

        idle_inputs();
        d_rstn = 1;
        repeat (2) tick();

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge c);
        #1;
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/counter_modulo_preset.md
Name: counter_modulo_preset

Overview:
- Parametrised up/down counter with preset load and a runtime-programmable modulo limit.
- Three modes: wrap, saturate and one-shot. One-shot is sequenced by a small FSM with start/busy/done handshake.
- Generic timing primitive for the video path (pixel/line/frame counters, blanking timers). Successor to the fixed-limit preset counter.

Parameters:
- BITS, 8, counter and limit width (>=1).
- MAXVALUE, 0, reset value of the limit register; 0 means 2^BITS-1.

Ports:
- c  in  1  clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear.
- en  in  1  count enable.
- dir  in  1  0 = count up, 1 = count down.
- ld  in  1  synchronous preset load.
- in  in  BITS  preset value.
- max_ld  in  1  load new limit.
- max_in  in  BITS  new limit value.
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (treated as wrap).
- start  in  1  one-shot start request.
- out  out  BITS  count value (registered).
- ovf  out  1  registered boundary-event pulse.
- tc  out  1  combinational terminal count: (dir=0 and out==limit) or (dir=1 and out==0).
- busy  out  1  one-shot run in progress.
- done  out  1  one-cycle one-shot completion pulse.

Behaviour:
- Clock and reset: single clock c. clr_n is asynchronous and active-low.
- Reset values: out=0, limit=(MAXVALUE?MAXVALUE:2^BITS-1), ovf=0, done=0, busy=0, FSM=IDLE.
- Priority per edge: clr_n > clr > ld > max_ld clamp > start > count.
- clr: out=0, FSM->IDLE, ovf=0, done=0; limit is kept.
- ld: out=min(in, limit_next), where limit_next = max_in if max_ld is asserted this cycle, else limit. FSM state is unchanged.
- max_ld: limit<=max_in. If out>max_in and no clr/ld this cycle, out<=max_in on the same edge. It may coincide with counting; the clamp wins.
- Count step, taken when en and no higher-priority action:
  - Up: out+1 if out<limit.
  - Down: out-1 if out>0.
- Boundary event (en with tc=1):
  - Wrap: up goes to 0, down goes to limit. ovf=1 in the same cycle out shows the wrapped value.
  - Saturate: out holds. ovf=1 for every cycle en is asserted at the boundary.
  - One-shot: out holds, FSM RUN->DONE, ovf=1.
- ovf is 0 in all other cycles.
- limit=0: out is stuck at 0. In wrap mode every en cycle is a boundary event, so ovf=1.
- One-shot FSM (active only when mode=10):
  - IDLE: on start, out<=0 (dir=0) or limit (dir=1), go to RUN. No counting in IDLE.
  - RUN: busy=1; counts on en. At a boundary event go to DONE. start is ignored.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE. A start during DONE is ignored.
  - Leaving mode 10, or clr, forces IDLE on the next edge with no done pulse.
- Wrap/saturate modes: FSM held in IDLE, busy=0, done=0; counting occurs whenever en.
- dir may change in any cycle. tc is evaluated with the current dir.
- All outputs except tc are registered. Load and count latency is 1 cycle.

Decomposition:
- Shared package (counter_pkg):
  - Mode encodings MODE_WRAP, MODE_SAT, MODE_ONESHOT.
  - FSM state encodings ST_IDLE, ST_RUN, ST_DONE.
  - Helper constant function for the default limit.
- One sub-module is natural: counter_oneshot_fsm, which holds the state register and produces busy, done and a run-enable to the datapath. The datapath (out, limit, ovf) stays in the top module.

Test Plan:
- Use BITS=3, MAXVALUE=0 for all scenarios.
- Reset and wrap: clr_n=0 then 1, mode=00, dir=0, en=1 for 9 cycles. Expect out 0,1..7,0,1; ovf=1 only on the cycle out returns to 0; tc=1 while out=7.
- Programmable limit: max_ld=1, max_in=5 while out=7. Next cycle out=5, limit=5; then counting gives 0,1..5,0. Next, ld=1, in=7 gives out=5 (clamped).
- Saturate down: mode=01, ld=1, in=2, dir=1, en=1 for 5 cycles. Expect out 2,1,0,0,0; ovf=1 on each of the cycles at 0 with en.
- One-shot: mode=10, limit=4, dir=0, pulse start, en=1. Expect busy=1, out 0..4; done=1 for one cycle after the boundary; busy=0; out holds 4; a further start restarts from 0.
- Async reset mid-run: assert clr_n=0 between clock edges during one-shot RUN. Expect immediately out=0, busy=0, done=0, ovf=0, limit=7, no done pulse.
- Simultaneous events: clr=1 with ld=1 and start=1 gives out=0, IDLE. ld=1, in=3 with en=1 gives out=3, no increment. limit=0 in wrap mode with en=1 gives out=0 and ovf=1 every cycle.
